uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  - UART transmitter; the send-side counterpart of uart_rx on the same serial link.
//  - Accepts one byte per tx_start strobe and serialises it onto tx, LSB first.
//  - Frame is start(0), 8 data bits, optional parity, then 1 or 2 stop(1) bits.
//  - Sits between the system-side byte producer and the board pin.
//  - Shares CPB and frame format with uart_rx so the two can be looped back directly.
// PARAMETERS
//  CPB        868  clocks per bit (100 MHz / 115200); must be >= 2; identical to uart_rx CPB
//  PARITY_EN  0    1 = insert parity bit after D7
//  PARITY_ODD 0    parity sense when PARITY_EN=1: 0 = even, 1 = odd
//  STOP_BITS  1    number of stop bits; legal values 1 or 2
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  rst       in   1  asynchronous, active-high reset
//  tx_start  in   1  request strobe; accepted only while tx_busy=0
//  tx_data   in   8  byte to send; sampled in the accept cycle only
//  tx        out  1  serial line; idles high
//  tx_busy   out  1  high from the cycle after accept until the frame ends
//  tx_done   out  1  one-cycle pulse when the final stop bit completes
// BEHAVIOUR
//  - Reset (async, any time): tx=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0.
//  - Reset mid-frame: line returns high immediately; frame is abandoned; no tx_done pulse.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - PARITY is skipped when PARITY_EN=0.
//  - Accept: in IDLE (or in the tx_done cycle), tx_start=1 latches tx_data into shift_reg.
//    - Next cycle: tx=0 and tx_busy=1 (latency 1 clk).
//  - Bit timing:
//    - clk_cnt counts 0..CPB-1; every bit is held for exactly CPB clocks.
//    - State or bit advances on clk_cnt==CPB-1.
//    - clk_cnt width is $clog2(CPB).
//  - DATA:
//    - bit_idx runs 0..7; tx = shift_reg[bit_idx].
//    - Leave DATA when bit_idx==7 and clk_cnt==CPB-1.
//  - PARITY: tx = ^byte XOR PARITY_ODD, computed from the latched byte, not live tx_data.
//  - STOP: tx=1 for STOP_BITS*CPB clocks.
//  - Frame end: on the last stop clock, tx_done=1 for one cycle and tx_busy goes to 0 in the same cycle.
//  - Frame length: CPB*(10+PARITY_EN+STOP_BITS-1) clocks from the first start-bit clock.
//  - tx_start while tx_busy=1 is ignored; no queuing; tx_data changes mid-frame have no effect.
//  - tx_start coincident with tx_done is accepted: the next start bit follows with zero idle gap.
//  - tx_start held high continuously sends back-to-back frames of the held tx_data.
//  - tx is a registered output, so the line has no glitches.
// STRUCTURE
//  - Shared include uart_defs.vh: FSM state localparams, default CPB, bit-count constants.
//    - uart_rx uses the same file.
//  - Sub-module uart_baud_cnt: clk_cnt plus a terminal-count flag.
//    - Cleared on accept; reusable by uart_rx.
//  - Top level holds the FSM, shift_reg, bit_idx, stop-bit counter and parity logic.
// TESTING (CPB=4 in simulation)
//  1. Reset: hold rst 5 clks -> tx=1, tx_busy=0, tx_done=0 throughout; no activity for 20 clks.
//  2. Send 0x5E:
//     - tx pattern per 4-clk slot is 0,0,1,1,1,1,0,1,0,1.
//     - tx_done pulses once, 40 clks after the first start clock.
//  3. Loopback: uart_tx.tx -> uart_rx.rx (same CPB), send 0xA5 then 0x00 -> rx_data 0xA5, 0x00.
//     - rx_done pulses once per byte.
//  4. tx_start pulsed again at clk 10 of a frame with tx_data=0xFF -> ignored; original byte sent intact.
//  5. tx_start held high with 0x5E and 0x3C:
//     - Second start bit begins the cycle after tx_done; no idle gap.
//     - Two frames occupy 80 clks.
//  6. PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 0x07:
//     - Parity slot tx=1; 2 stop slots; tx_done at clk 48.
//  7. Assert rst at clk 17 of a frame -> tx=1 in the same cycle, tx_busy=0, no tx_done.
//     - After release, the next send is clean.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame constants
// and the parity helper. The receive side is expected to import the same package.
package uart_tx_pkg;

    localparam int CPB_DEFAULT = 868;
    localparam int DATA_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // XOR-reduce the byte; odd=1 inverts the sense so the frame carries an odd count of ones.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CPB-1 while running and flags the terminal count.
// Cleared when a new frame is accepted so every frame starts on a fresh bit period.
module uart_baud_cnt #(
    parameter  int CPB   = 868,
    localparam int CNT_W = $clog2(CPB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_run,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end = (r_cnt == CNT_W'(CPB - 1));

    // Free-running bit-period counter, held at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run || w_at_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = i_run && w_at_end;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; next-cycle values are computed combinationally.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CPB        = CPB_DEFAULT,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CPB);

    tx_state_e        r_state;
    tx_state_e        w_state_next;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic             r_stop_idx;
    logic             w_stop_idx_next;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             w_tx_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic             w_run;
    logic             w_accept;
    logic             w_last_stop;
    logic             w_frame_end;

    assign w_run       = (r_state != ST_IDLE);
    assign w_last_stop = (r_state == ST_STOP) && (r_stop_idx == 1'(STOP_BITS - 1));
    assign w_frame_end = w_last_stop && w_tc;
    // The tx_done cycle doubles as an accept slot, giving zero-gap back-to-back frames.
    assign w_accept    = tx_start && ((r_state == ST_IDLE) || w_frame_end);

    uart_baud_cnt #(.CPB(CPB)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_run   (w_run),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and bit/stop index sequencing.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   w_state_next = w_accept ? ST_START : ST_IDLE;
            ST_START:  w_state_next = w_tc ? ST_DATA : ST_START;
            ST_DATA: begin
                if (w_tc && (r_bit_idx == 3'd7)) begin
                    w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_PARITY: w_state_next = w_tc ? ST_STOP : ST_PARITY;
            ST_STOP: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                end else if (w_frame_end) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            default:   w_state_next = ST_IDLE;
        endcase

        if (r_state != ST_DATA) begin
            w_bit_idx_next = 3'd0;
        end else if (w_tc) begin
            w_bit_idx_next = r_bit_idx + 3'd1;
        end else begin
            w_bit_idx_next = r_bit_idx;
        end

        if ((r_state != ST_STOP) || w_frame_end) begin
            w_stop_idx_next = 1'b0;
        end else if (w_tc) begin
            w_stop_idx_next = r_stop_idx + 1'b1;
        end else begin
            w_stop_idx_next = r_stop_idx;
        end
    end

    // Output values for the coming cycle; done/busy flip one clock early so they land on the last stop clock.
    always_comb begin
        w_done_next = w_last_stop && (w_cnt == CNT_W'(CPB - 2));
        w_busy_next = (w_state_next != ST_IDLE) && !w_done_next;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_shift[w_bit_idx_next];
            ST_PARITY: w_tx_next = parity_bit(r_shift, 1'(PARITY_ODD));
            ST_STOP:   w_tx_next = 1'b1;
            ST_IDLE:   w_tx_next = 1'b1;
            default:   w_tx_next = 1'b1;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_shift    <= w_accept ? tx_data : r_shift;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a driver predicts accepted frames into a queue,
// a line monitor decodes tx sample-by-sample and compares against the expected frame.
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] start_w;
    logic [7:0] data_w [3];
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int   sel        = 0;
    int   cyc        = 0;
    int   free_edge  = 0;
    int   n_acc      = 0;
    int   n_checks   = 0;
    int   n_err      = 0;
    bit   in_frame   = 1'b0;
    exp_t exp_q [$];

    uart_tx #(.CPB(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_start(start_w[0]), .tx_data(data_w[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx #(.CPB(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
        .clk(clk), .rst(rst), .tx_start(start_w[1]), .tx_data(data_w[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx #(.CPB(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst(rst), .tx_start(start_w[2]), .tx_data(data_w[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cpb_of(input int s);
        return (s == 2) ? 2 : 4;
    endfunction

    function automatic bit pe_of(input int s);
        return (s != 0);
    endfunction

    function automatic bit po_of(input int s);
        return (s == 2);
    endfunction

    function automatic int sb_of(input int s);
        return (s == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int s);
        return cpb_of(s) * (10 + int'(pe_of(s)) + sb_of(s) - 1);
    endfunction

    // Expected line level for a given bit slot of the frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int slot, input int s);
        int ones;
        ones = $countones(d);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (pe_of(s) && slot == 9) return (((ones % 2) == 1) ? 1'b1 : 1'b0) ^ po_of(s);
        return 1'b1;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s (cfg %0d, cyc %0d): actual=%0h expected=%0h", name, sel, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; the model decides acceptance from its own frame timing.
    task automatic step(input logic s, input logic [7:0] d);
        int acc;
        start_w = 3'b000;
        start_w[sel] = s;
        data_w[sel] = d;
        acc = cyc + 1;
        if (s && acc >= free_edge) begin
            exp_q.push_back('{data: d, start_cyc: acc});
            free_edge = acc + frame_len(sel);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || in_frame) && g < 400) begin
            step(1'b0, 8'h00);
            g++;
        end
        chk(exp_q.size() == 0 && !in_frame, "drain_timeout", g, 0);
    endtask

    task automatic rand_run(input int n);
        repeat (n) step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 8'($urandom));
    endtask

    // Line monitor: pops an expectation when a start bit appears and checks every sample of the frame.
    initial begin : monitor
        exp_t cur;
        int   pos;
        int   mlen;
        logic eb;
        pos  = 0;
        mlen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                chk(tx_w[sel] === 1'b1 && busy_w[sel] === 1'b0 && done_w[sel] === 1'b0,
                    "reset_outputs", {29'd0, tx_w[sel], busy_w[sel], done_w[sel]}, 3'b100);
            end else begin
                if (!in_frame) begin
                    if (tx_w[sel] === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            chk(1'b0, "unexpected_start", cyc, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            chk(cyc == cur.start_cyc, "start_time", cyc, cur.start_cyc);
                            in_frame = 1'b1;
                            pos = 0;
                            mlen = frame_len(sel);
                        end
                    end else begin
                        chk(tx_w[sel] === 1'b1 && busy_w[sel] === 1'b0 && done_w[sel] === 1'b0,
                            "idle_outputs", {29'd0, tx_w[sel], busy_w[sel], done_w[sel]}, 3'b100);
                    end
                end
                if (in_frame) begin
                    eb = frame_bit(cur.data, pos / cpb_of(sel), sel);
                    chk(tx_w[sel] === eb, "tx_bit", {31'd0, tx_w[sel]}, {31'd0, eb});
                    chk(done_w[sel] === (pos == mlen - 1), "tx_done", {31'd0, done_w[sel]}, int'(pos == mlen - 1));
                    chk(busy_w[sel] === (pos != mlen - 1), "tx_busy", {31'd0, busy_w[sel]}, int'(pos != mlen - 1));
                    pos++;
                    if (pos == mlen) in_frame = 1'b0;
                end
            end
        end
    end

    initial begin : driver
        int g;
        rst = 1'b1;
        start_w = 3'b000;
        for (int i = 0; i < 3; i++) data_w[i] = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) step(1'b0, 8'($urandom));

        // Single frame, then two frames as a receiver would see them.
        step(1'b1, 8'h5E);
        drain();
        step(1'b1, 8'hA5);
        drain();
        step(1'b1, 8'h00);
        drain();

        // A second request mid-frame with different data must be ignored.
        step(1'b1, 8'h3C);
        repeat (8) step(1'b0, 8'h00);
        step(1'b1, 8'hFF);
        drain();

        // Held request: two back-to-back frames, data changes while held.
        n_acc = 0;
        g = 0;
        while (n_acc < 2 && g < 200) begin
            step(1'b1, (n_acc == 0) ? 8'h5E : 8'h3C);
            g++;
        end
        chk(n_acc == 2, "held_start_accepts", n_acc, 2);
        step(1'b0, 8'h00);
        drain();

        // Reset in the middle of a frame: line high at once, frame abandoned.
        step(1'b1, 8'hC3);
        repeat (15) step(1'b0, 8'h00);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk(tx_w[sel] === 1'b1, "midframe_reset_tx", {31'd0, tx_w[sel]}, 1);
        chk(busy_w[sel] === 1'b0, "midframe_reset_busy", {31'd0, busy_w[sel]}, 0);
        chk(done_w[sel] === 1'b0, "midframe_reset_done", {31'd0, done_w[sel]}, 0);
        exp_q.delete();
        free_edge = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h96);
        drain();
        rand_run(300);
        drain();

        // Even parity, two stop bits.
        sel = 1;
        step(1'b1, 8'h07);
        drain();
        rand_run(300);
        drain();

        // Odd parity at the minimum bit period.
        sel = 2;
        step(1'b1, 8'h07);
        drain();
        rand_run(300);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
